alu_share_arbiter: RTL and testbench

- Shares one ALU instance between two requesters: A (execute stage) and B (address/PC-update path).
- Round-robin arbitration, registered operands, a fixed-latency execute window and a held response per requester.
- Illegal ALU operation codes are flagged instead of propagating X.
- Sits between the pipeline control and the ALU, and owns the ALU's `rs1`/`rs2`/`alu_sel` inputs.

---
 rtl/alu_ctrl_pkg.sv | 20 ++
 rtl/ALU_riscv.sv | 23 ++
 rtl/alu_share_arbiter.sv | 155 +++++++++++++++
 tb/tb_alu_share_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sharing arbiter: opcodes, FSM encoding
// and the opcode legality check.
package alu_ctrl_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b1000;
   localparam logic [3:0] ALU_OR  = 4'b0110;
   localparam logic [3:0] ALU_AND = 4'b0111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   function automatic logic alu_op_legal(input logic [3:0] sel);
      return (sel == ALU_ADD) || (sel == ALU_SUB) || (sel == ALU_OR) || (sel == ALU_AND);
   endfunction

endpackage

// File: rtl/ALU_riscv.sv
// Combinational RISC-V style ALU: add, subtract, or, and.
// Unknown opcodes produce zero so no X leaks out.
module ALU_riscv
   import alu_ctrl_pkg::*;
(
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic [3:0]  alu_sel,
   output logic [31:0] alu_out
);

   always_comb begin
      alu_out = '0;
      case (alu_sel)
         ALU_ADD: alu_out = rs1 + rs2;
         ALU_SUB: alu_out = rs1 + ~rs2 + 32'd1;
         ALU_OR:  alu_out = rs1 | rs2;
         ALU_AND: alu_out = rs1 & rs2;
         default: alu_out = '0;
      endcase
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between requesters A and B, with
// registered operands, a fixed execute window and a held response per port.
module alu_share_arbiter
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned EXEC_CYCLES = 1,
   parameter int unsigned XLEN        = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            a_req_valid,
   output logic            a_req_ready,
   input  logic [XLEN-1:0] a_rs1,
   input  logic [XLEN-1:0] a_rs2,
   input  logic [3:0]      a_sel,
   output logic            a_rsp_valid,
   input  logic            a_rsp_ready,
   output logic [XLEN-1:0] a_rsp_data,
   output logic            a_rsp_err,
   input  logic            b_req_valid,
   output logic            b_req_ready,
   input  logic [XLEN-1:0] b_rs1,
   input  logic [XLEN-1:0] b_rs2,
   input  logic [3:0]      b_sel,
   output logic            b_rsp_valid,
   input  logic            b_rsp_ready,
   output logic [XLEN-1:0] b_rsp_data,
   output logic            b_rsp_err,
   output logic            busy,
   output logic [1:0]      dbg_state_o
);

   localparam logic [3:0] EXEC_LD = 4'(EXEC_CYCLES);

   // Handshake: a request transfers on the rising edge where req_valid and
   // req_ready are both high; a response transfers where rsp_valid and
   // rsp_ready are both high. rsp_valid/data/err stay stable until then.

   state_e          state_q, state_d;
   logic            prio_q, prio_d;     // 0: A wins a tie, 1: B wins
   logic            owner_q, owner_d;   // 0: A, 1: B
   logic [3:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] rs1_q, rs2_q;
   logic [3:0]      sel_q;
   logic            a_vld_q, b_vld_q, a_err_q, b_err_q;
   logic [XLEN-1:0] a_data_q, b_data_q;
   logic [XLEN-1:0] alu_out;
   logic            a_hs, b_hs, load, capture, clear;

   // rst_n gates ready so nothing is accepted while reset is held.
   assign a_req_ready = rst_n && (state_q == ST_IDLE) && a_req_valid && (!b_req_valid || !prio_q);
   assign b_req_ready = rst_n && (state_q == ST_IDLE) && b_req_valid && (!a_req_valid || prio_q);
   assign a_hs        = a_req_valid && a_req_ready;
   assign b_hs        = b_req_valid && b_req_ready;

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      capture = 1'b0;
      clear   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (a_hs || b_hs) begin
               load    = 1'b1;
               owner_d = b_hs;
               prio_d  = !b_hs;
               cnt_d   = EXEC_LD;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (cnt_q == 4'd0) begin
               capture = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if ((!owner_q && a_vld_q && a_rsp_ready) || (owner_q && b_vld_q && b_rsp_ready)) begin
               clear   = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         prio_q  <= 1'b0;
         owner_q <= 1'b0;
         cnt_q   <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         sel_q   <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         if (load) begin
            rs1_q <= b_hs ? b_rs1 : a_rs1;
            rs2_q <= b_hs ? b_rs2 : a_rs2;
            sel_q <= b_hs ? b_sel : a_sel;
         end
      end
   end

   ALU_riscv u_alu (
      .rs1     (rs1_q),
      .rs2     (rs2_q),
      .alu_sel (sel_q),
      .alu_out (alu_out)
   );

   // Illegal opcodes report zero data with err set, ignoring the ALU output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_vld_q  <= 1'b0;
         b_vld_q  <= 1'b0;
         a_err_q  <= 1'b0;
         b_err_q  <= 1'b0;
         a_data_q <= '0;
         b_data_q <= '0;
      end else if (capture) begin
         if (!owner_q) begin
            a_vld_q  <= 1'b1;
            a_err_q  <= !alu_op_legal(sel_q);
            a_data_q <= alu_op_legal(sel_q) ? alu_out : '0;
         end else begin
            b_vld_q  <= 1'b1;
            b_err_q  <= !alu_op_legal(sel_q);
            b_data_q <= alu_op_legal(sel_q) ? alu_out : '0;
         end
      end else if (clear) begin
         if (!owner_q) a_vld_q <= 1'b0;
         else          b_vld_q <= 1'b0;
      end
   end

   assign a_rsp_valid = a_vld_q;
   assign a_rsp_data  = a_data_q;
   assign a_rsp_err   = a_err_q;
   assign b_rsp_valid = b_vld_q;
   assign b_rsp_data  = b_data_q;
   assign b_rsp_err   = b_err_q;
   assign busy        = (state_q != ST_IDLE);
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a default-latency instance plus an
// EXEC_CYCLES=3 instance used for the reset-during-execute scenario.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, rst_n3;
  logic        a_req_valid, b_req_valid, a_rsp_ready, b_rsp_ready;
  logic [31:0] a_rs1, a_rs2, b_rs1, b_rs2;
  logic [3:0]  a_sel, b_sel;

  logic        a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, a_rsp_err, b_rsp_err, busy;
  logic [31:0] a_rsp_data, b_rsp_data;
  logic [1:0]  dbg_state;

  logic        a_req_ready3, b_req_ready3, a_rsp_valid3, b_rsp_valid3, a_rsp_err3, b_rsp_err3, busy3;
  logic [31:0] a_rsp_data3, b_rsp_data3;
  logic [1:0]  dbg_state3;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  alu_share_arbiter u_dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_rs1(a_rs1), .a_rs2(a_rs2), .a_sel(a_sel),
    .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_data(a_rsp_data), .a_rsp_err(a_rsp_err),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_rs1(b_rs1), .b_rs2(b_rs2), .b_sel(b_sel),
    .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_data(b_rsp_data), .b_rsp_err(b_rsp_err),
    .busy(busy), .dbg_state_o(dbg_state)
  );

  alu_share_arbiter #(.EXEC_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n3),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready3), .a_rs1(a_rs1), .a_rs2(a_rs2), .a_sel(a_sel),
    .a_rsp_valid(a_rsp_valid3), .a_rsp_ready(a_rsp_ready), .a_rsp_data(a_rsp_data3), .a_rsp_err(a_rsp_err3),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready3), .b_rs1(b_rs1), .b_rs2(b_rs2), .b_sel(b_sel),
    .b_rsp_valid(b_rsp_valid3), .b_rsp_ready(b_rsp_ready), .b_rsp_data(b_rsp_data3), .b_rsp_err(b_rsp_err3),
    .busy(busy3), .dbg_state_o(dbg_state3)
  );

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit is_b, input logic [31:0] r1, input logic [31:0] r2, input logic [3:0] sel);
    if (is_b) begin b_req_valid = 1'b1; b_rs1 = r1; b_rs2 = r2; b_sel = sel; end
    else      begin a_req_valid = 1'b1; a_rs1 = r1; a_rs2 = r2; a_sel = sel; end
  endtask

  // Wait (bounded) for the selected port's ready on the default instance.
  task automatic wait_ready(input bit is_b, input string tag);
    int n = 0;
    while (!(is_b ? b_req_ready : a_req_ready) && n < 20) begin tick(); n++; end
    check({tag, "_ready"}, {31'd0, (is_b ? b_req_ready : a_req_ready)}, 32'd1);
  endtask

  // After the accept edge, count edges until the port's rsp_valid rises.
  task automatic wait_rsp(input bit is_b, output int lat);
    lat = 0;
    do begin tick(); lat++; end while (!(is_b ? b_rsp_valid : a_rsp_valid) && lat < 20);
  endtask

  task automatic run_op(input bit is_b, input logic [31:0] r1, input logic [31:0] r2, input logic [3:0] sel,
                        input logic [31:0] exp_d, input logic exp_e, input string tag);
    int lat;
    drive_req(is_b, r1, r2, sel);
    #1;
    wait_ready(is_b, tag);
    tick();
    if (is_b) b_req_valid = 1'b0; else a_req_valid = 1'b0;
    wait_rsp(is_b, lat);
    exp_q.push_back(exp_d);
    check({tag, "_lat"}, lat, 32'd2);
    check({tag, "_data"}, is_b ? b_rsp_data : a_rsp_data, exp_q.pop_front());
    check({tag, "_err"}, {31'd0, (is_b ? b_rsp_err : a_rsp_err)}, {31'd0, exp_e});
    check({tag, "_other_vld"}, {31'd0, (is_b ? a_rsp_valid : b_rsp_valid)}, 32'd0);
    tick();
    check({tag, "_rsp_clr"}, {31'd0, (is_b ? b_rsp_valid : a_rsp_valid)}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    bit gb;
    rst_n = 1'b0; rst_n3 = 1'b0;
    a_req_valid = 1'b1; b_req_valid = 1'b0; a_rsp_ready = 1'b1; b_rsp_ready = 1'b1;
    a_rs1 = '0; a_rs2 = '0; b_rs1 = '0; b_rs2 = '0; a_sel = '0; b_sel = '0;
    repeat (3) tick();
    check("rst_a_ready", {31'd0, a_req_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_a_rsp", {a_rsp_valid, a_rsp_err, a_rsp_data[29:0]}, 32'd0);
    check("rst_b_rsp", {b_rsp_valid, b_rsp_err, b_rsp_data[29:0]}, 32'd0);
    a_req_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // 1: A only, add
    run_op(1'b0, 32'd5, 32'd3, 4'b0000, 32'd8, 1'b0, "t1_add");

    // 2: B subtract / or / and
    run_op(1'b1, 32'h10, 32'h11, 4'b1000, 32'hFFFF_FFFF, 1'b0, "t2_sub");
    run_op(1'b1, 32'hF0F0, 32'h0F0F, 4'b0110, 32'h0000_FFFF, 1'b0, "t2_or");
    run_op(1'b1, 32'hF0F0, 32'h0FF0, 4'b0111, 32'h0000_00F0, 1'b0, "t2_and");

    // 3: both valid continuously, grants alternate starting with A
    for (int i = 0; i < 6; i++) begin
      drive_req(1'b0, 32'(i), 32'd1000, 4'b0000);
      drive_req(1'b1, 32'(i), 32'd2000, 4'b0000);
      #1;
      for (int n = 0; n < 20 && !(a_req_ready || b_req_ready); n++) tick();
      gb = b_req_ready;
      check("t3_grant", {31'd0, gb}, 32'(i % 2));
      check("t3_one_hot", {31'd0, (a_req_ready && b_req_ready)}, 32'd0);
      exp_q.push_back(gb ? 32'(i) + 32'd2000 : 32'(i) + 32'd1000);
      tick();
      wait_rsp(gb, lat);
      check("t3_lat", lat, 32'd2);
      check("t3_data", gb ? b_rsp_data : a_rsp_data, exp_q.pop_front());
      check("t3_other_vld", {31'd0, (gb ? a_rsp_valid : b_rsp_valid)}, 32'd0);
      tick();
    end
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    tick();

    // 4: illegal opcodes on A
    run_op(1'b0, 32'd7, 32'd9, 4'b0011, 32'd0, 1'b1, "t4_ill3");
    run_op(1'b0, 32'd7, 32'd9, 4'b1110, 32'd0, 1'b1, "t4_illE");

    // 5: A response backpressure while B waits
    a_rsp_ready = 1'b0;
    drive_req(1'b0, 32'd7, 32'd9, 4'b0000);
    #1;
    wait_ready(1'b0, "t5_a");
    tick();
    a_req_valid = 1'b0;
    drive_req(1'b1, 32'd4, 32'd4, 4'b0000);
    wait_rsp(1'b0, lat);
    check("t5_lat", lat, 32'd2);
    for (int k = 0; k < 5; k++) begin
      check("t5_hold_vld", {31'd0, a_rsp_valid}, 32'd1);
      check("t5_hold_data", a_rsp_data, 32'd16);
      check("t5_b_blocked", {31'd0, b_req_ready}, 32'd0);
      tick();
    end
    a_rsp_ready = 1'b1;
    tick();
    check("t5_a_released", {31'd0, a_rsp_valid}, 32'd0);
    check("t5_b_ready", {31'd0, b_req_ready}, 32'd1);
    tick();
    b_req_valid = 1'b0;
    check("t5_busy", {31'd0, busy}, 32'd1);
    wait_rsp(1'b1, lat);
    check("t5_b_lat", lat, 32'd2);
    check("t5_b_data", b_rsp_data, 32'd8);
    tick();

    // 6: reset during execute on the EXEC_CYCLES=3 instance
    rst_n = 1'b0;
    rst_n3 = 1'b1;
    tick();
    drive_req(1'b0, 32'd2, 32'd2, 4'b0000);
    #1;
    check("t6_a_ready", {31'd0, a_req_ready3}, 32'd1);
    tick();
    a_req_valid = 1'b0;
    tick();
    check("t6_exec_busy", {31'd0, busy3}, 32'd1);
    rst_n3 = 1'b0;
    #1;
    check("t6_rst_busy", {31'd0, busy3}, 32'd0);
    check("t6_rst_outs", {a_rsp_valid3, b_rsp_valid3, a_rsp_err3, b_rsp_err3, a_req_ready3, b_req_ready3, 26'd0}, 32'd0);
    tick();
    rst_n3 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t6_no_rsp", {31'd0, (a_rsp_valid3 || b_rsp_valid3)}, 32'd0);
    end
    drive_req(1'b0, 32'd20, 32'd22, 4'b0000);
    drive_req(1'b1, 32'd1, 32'd1, 4'b0000);
    #1;
    check("t6_prio_a", {30'd0, a_req_ready3, b_req_ready3}, 32'd2);
    tick();
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    lat = 0;
    do begin tick(); lat++; end while (!a_rsp_valid3 && lat < 20);
    check("t6_lat", lat, 32'd4);
    check("t6_data", a_rsp_data3, 32'd42);
    check("t6_err", {31'd0, a_rsp_err3}, 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
